// File: rtl/ex_mul_seq_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: ALU command codes,
// sequencer state codes and the operand width.
package ex_mul_seq_pkg;

  localparam int MUL_W = 16;

  localparam logic [2:0] ALU_NC  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/ex_mul_seq_if.sv
// Bundle between the multiply sequencer and the EX stage. The slave modport is
// the sequencer; the master modport is the EX stage that owns the shared ALU.
interface ex_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             alu_req;
  logic [2:0]       alu_cmd;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [WIDTH-1:0] alu_result;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output alu_req, alu_cmd, alu_src1, alu_src2, stall_req, busy, done, product
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  alu_req, alu_cmd, alu_src1, alu_src2, stall_req, busy, done, product
  );
endinterface

// File: rtl/ex_mul_seq.sv
// Multi-cycle 16x16 (low half) multiply that borrows the shared EX-stage ALU
// for a shift-add sequence, stalling the front of the pipeline while it runs.
module ex_mul_seq
  import ex_mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  ex_mul_seq_if.slave  bus
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_product;

  logic w_run;
  logic w_run_last;

  assign w_run = (r_state == MUL_RUN);

  // Stop once no higher multiplier bits remain, so short multipliers finish early.
  assign w_run_last = (r_mplier[WIDTH-1:1] == '0) || (r_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= MUL_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (bus.start) begin
            r_acc    <= '0;
            r_mcand  <= bus.op_a;
            r_mplier <= bus.op_b;
            r_cnt    <= '0;
            if (bus.op_b == '0) begin
              r_state   <= MUL_DONE;
              r_product <= '0;
            end else begin
              r_state <= MUL_RUN;
            end
          end
        end
        MUL_RUN: begin
          r_acc    <= bus.alu_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 4'd1;
          if (w_run_last) begin
            r_state   <= MUL_DONE;
            r_product <= bus.alu_result;
          end
        end
        MUL_DONE: r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

  assign bus.alu_req   = w_run;
  assign bus.alu_cmd   = w_run ? ALU_ADD : ALU_NC;
  assign bus.alu_src1  = w_run ? r_acc : '0;
  assign bus.alu_src2  = (w_run && r_mplier[0]) ? r_mcand : '0;
  // Released in DONE so the pipeline advances and captures the product.
  assign bus.stall_req = ((r_state == MUL_IDLE) && bus.start) || w_run;
  assign bus.busy      = (r_state != MUL_IDLE);
  assign bus.done      = (r_state == MUL_DONE);
  assign bus.product   = r_product;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Bench for ex_mul_seq: directed vector table, hand-written stall/reset
// sequences, then random operands against an arithmetic reference model.
module tb_ex_mul_seq;
  import ex_mul_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ex_mul_seq_if #(.WIDTH(16)) bus ();

  ex_mul_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // Shared ALU of the EX stage: combinational add, idle otherwise.
  assign bus.alu_result = (bus.alu_cmd == ALU_ADD) ? (bus.alu_src1 + bus.alu_src2) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          k;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_k(input logic [15:0] b);
    int k;
    k = 0;
    for (int i = 0; i < 16; i++)
      if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = {16'h0, a} * {16'h0, b};
    return full[15:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".rst_req"},   {31'h0, bus.alu_req},   32'h0);
    check({tag, ".rst_cmd"},   {29'h0, bus.alu_cmd},   {29'h0, ALU_NC});
    check({tag, ".rst_src1"},  {16'h0, bus.alu_src1},  32'h0);
    check({tag, ".rst_src2"},  {16'h0, bus.alu_src2},  32'h0);
    check({tag, ".rst_stall"}, {31'h0, bus.stall_req}, 32'h0);
    check({tag, ".rst_busy"},  {31'h0, bus.busy},      32'h0);
    check({tag, ".rst_done"},  {31'h0, bus.done},      32'h0);
    check({tag, ".rst_prod"},  {16'h0, bus.product},   32'h0);
  endtask

  // Called mid-cycle in IDLE; returns mid-cycle one cycle after done.
  // inj > 0 pulses a competing start in that RUN cycle; rst_at > 0 aborts there.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input int k,
                         input int inj, input int rst_at, input string tag);
    int nreq;
    nreq = 0;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    #1;
    check({tag, ".stall_T"}, {31'h0, bus.stall_req}, 32'h1);
    check({tag, ".req_T"},   {31'h0, bus.alu_req},   32'h0);
    check({tag, ".busy_T"},  {31'h0, bus.busy},      32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = 16'($urandom);
    bus.op_b  = 16'($urandom);
    for (int c = 1; c <= k; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, ".abort"});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        return;
      end
      if (c == inj) begin
        bus.start = 1'b1;
        bus.op_a  = 16'h0009;
        bus.op_b  = 16'h0009;
      end
      #1;
      if (bus.alu_req === 1'b1) nreq++;
      check({tag, ".cmd_run"},   {29'h0, bus.alu_cmd},   {29'h0, ALU_ADD});
      check({tag, ".stall_run"}, {31'h0, bus.stall_req}, 32'h1);
      check({tag, ".busy_run"},  {31'h0, bus.busy},      32'h1);
      check({tag, ".done_run"},  {31'h0, bus.done},      32'h0);
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    check({tag, ".req_cycles"}, nreq, k);
    check({tag, ".done"},     {31'h0, bus.done},      32'h1);
    check({tag, ".product"},  {16'h0, bus.product},   {16'h0, exp_p});
    check({tag, ".stall_D"},  {31'h0, bus.stall_req}, 32'h0);
    check({tag, ".req_D"},    {31'h0, bus.alu_req},   32'h0);
    check({tag, ".src_D"},    {bus.alu_src1, bus.alu_src2}, 32'h0);
    check({tag, ".cmd_D"},    {29'h0, bus.alu_cmd},   {29'h0, ALU_NC});
    @(negedge clk);
    #1;
    check({tag, ".done_off"}, {31'h0, bus.done},    32'h0);
    check({tag, ".idle"},     {31'h0, bus.busy},    32'h0);
    check({tag, ".held"},     {16'h0, bus.product}, {16'h0, exp_p});
  endtask

  vec_t vecs[6];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.op_a  = 16'h0;
    bus.op_b  = 16'h0;
    rst_n     = 1'b0;

    vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 3};
    vecs[1] = '{16'h1234, 16'h0000, 16'h0000, 0};
    vecs[2] = '{16'hFFFF, 16'h8000, 16'h8000, 16};
    vecs[3] = '{16'hFFFD, 16'h0007, 16'hFFEB, 3};
    vecs[4] = '{16'h0100, 16'h0100, 16'h0000, 9};
    vecs[5] = '{16'h0006, 16'h0007, 16'h002A, 3};

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_mul(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].k, 0, 0, $sformatf("vec%0d", i));

    // Competing start in RUN must be dropped.
    run_mul(16'h0003, 16'h0005, 16'h000F, 3, 2, 0, "ignore_start");
    // Second run aborted by reset at T+2, then a clean 6x7.
    run_mul(16'h0003, 16'h0005, 16'h000F, 3, 0, 2, "abort");
    run_mul(16'h0006, 16'h0007, 16'd42, 3, 0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b, m;
      a = 16'($urandom);
      m = 16'((32'h1 << $urandom_range(0, 16)) - 1);
      b = 16'($urandom) & m;
      run_mul(a, b, model_prod(a, b), model_k(b), 0, 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
